input_port_ctrl: RTL and testbench

//  Parametrised successor to the switch input path: CHANNELS banks of DATA_W switches feed the CPU's IN instruction.
//  On a CPU request, stalls the core through halt until the user presses a debounced confirm button.

---
 rtl/io_pkg.sv | 16 +
 rtl/btn_debounce.sv | 75 +++++++
 rtl/input_port_ctrl.sv | 175 +++++++++++++++++
 tb/tb_input_port_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the switch input path: FSM state encoding and
// default sizing used by input_port_ctrl and btn_debounce.
package io_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_OUT_W           = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } io_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser chain, stability counter and rising
// edge detector. The debounced level follows the synchronised input only after
// DEBOUNCE_CYCLES consecutive equal samples; press is a 1-cycle pulse on the
// debounced rising edge. Generic so other board buttons can reuse it.
module btn_debounce
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   samp_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   level_r;
  logic                   press_r;
  logic                   level_nxt_s;

  // Shift the raw button through the synchroniser chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
    end
  end

  // Count consecutive equal samples; any change restarts at one, and the count saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      samp_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (sync_r[SYNC_STAGES-1] != samp_r) begin
      samp_r <= sync_r[SYNC_STAGES-1];
      cnt_r  <= CNT_W'(1);
    end else if (cnt_r != CNT_W'(DEBOUNCE_CYCLES)) begin
      cnt_r  <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  // Accept the sampled level once it has been stable long enough.
  always_comb begin
    level_nxt_s = level_r;
    if (cnt_r == CNT_W'(DEBOUNCE_CYCLES)) begin
      level_nxt_s = samp_r;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Register the debounced level and its rising-edge pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      press_r <= ~level_r & level_nxt_s;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/input_port_ctrl.sv
// Switch input path for the CPU IN instruction. A request stalls the core via
// halt until the user confirms with the debounced button; the selected switch
// bank is then captured, zero/sign-extended and strobed to the register bank.
// Optional feature macro: IN_TIMEOUT_EN (gives up after TIMEOUT_CYCLES in
// ARM/WAIT, returning zero with a timeout strobe).
module input_port_ctrl
  import io_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int CHANNELS        = 2,
  parameter int CH_W            = 1,
  parameter int OUT_W           = DEF_OUT_W,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef IN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1000000
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_req,
  input  logic [CH_W-1:0]            in_chan,
  input  logic                       in_signed,
  input  logic [CHANNELS*DATA_W-1:0] switches,
  input  logic                       confirm_btn,
  output logic                       halt,
  output logic [OUT_W-1:0]           data_out,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       timeout
);

  io_state_e         state_r;
  io_state_e         state_nxt_s;
  logic [CH_W-1:0]   chan_r;
  logic              signed_r;
  logic              btn_level_s;
  logic              btn_press_s;
  logic              in_wait_s;
  logic              tmo_hit_s;
  logic [DATA_W-1:0] bank_s;
  logic [OUT_W-1:0]  sign_fill_s;
  logic [OUT_W-1:0]  ext_s;
  logic              halt_r;
  logic              busy_r;
  logic              data_valid_r;
  logic              timeout_r;
  logic [OUT_W-1:0]  data_out_r;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clock (clock),
    .reset (reset),
    .btn   (confirm_btn),
    .level (btn_level_s),
    .press (btn_press_s)
  );

  assign in_wait_s = (state_r == ST_ARM) || (state_r == ST_WAIT);

`ifdef IN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Count cycles spent waiting for the user; cleared whenever not waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (in_wait_s && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

  assign tmo_hit_s = in_wait_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Select the latched bank; an out-of-range channel reads as zero.
  always_comb begin
    bank_s = {DATA_W{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      bank_s = (chan_r == CH_W'(k)) ? switches[k*DATA_W +: DATA_W] : bank_s;
    end
  end

  // Zero- or sign-extend the bank; with OUT_W == DATA_W the fill shifts out entirely.
  always_comb begin
    sign_fill_s = {OUT_W{signed_r & bank_s[DATA_W-1]}} << DATA_W;
    ext_s       = OUT_W'(bank_s) | sign_fill_s;
  end

  // Next-state logic for the request/confirm/capture sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_req) state_nxt_s = ST_ARM;
        else        state_nxt_s = ST_IDLE;
      end
      ST_ARM: begin
        if (tmo_hit_s)         state_nxt_s = ST_DONE;
        else if (!btn_level_s) state_nxt_s = ST_WAIT;
        else                   state_nxt_s = ST_ARM;
      end
      ST_WAIT: begin
        if (tmo_hit_s)        state_nxt_s = ST_DONE;
        else if (btn_press_s) state_nxt_s = ST_CAPTURE;
        else                  state_nxt_s = ST_WAIT;
      end
      ST_CAPTURE: state_nxt_s = ST_DONE;
      ST_DONE:    state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch channel and extension mode only when a request is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      chan_r   <= {CH_W{1'b0}};
      signed_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && in_req) begin
      chan_r   <= in_chan;
      signed_r <= in_signed;
    end else begin
      chan_r   <= chan_r;
      signed_r <= signed_r;
    end
  end

  // Registered outputs, derived from the next state so halt drops with data_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      halt_r       <= 1'b0;
      busy_r       <= 1'b0;
      data_valid_r <= 1'b0;
      timeout_r    <= 1'b0;
      data_out_r   <= {OUT_W{1'b0}};
    end else begin
      halt_r       <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_WAIT) ||
                      (state_nxt_s == ST_CAPTURE);
      busy_r       <= (state_nxt_s != ST_IDLE);
      data_valid_r <= (state_nxt_s == ST_DONE);
      timeout_r    <= tmo_hit_s;
      if (state_r == ST_CAPTURE) begin
        data_out_r <= ext_s;
      end else if (tmo_hit_s) begin
        data_out_r <= {OUT_W{1'b0}};
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign halt       = halt_r;
  assign busy       = busy_r;
  assign data_valid = data_valid_r;
  assign timeout    = timeout_r;
  assign data_out   = data_out_r;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Scoreboard bench for input_port_ctrl: expected results are queued when a
// request is accepted and compared when data_valid strobes. A second instance
// with CHANNELS=1 covers the out-of-range channel. Build with IN_TIMEOUT_EN
// defined to exercise the timeout path.
module tb_input_port_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_req;
  logic        in_chan;
  logic        in_signed;
  logic [31:0] switches;
  logic        confirm_btn;
  logic        halt, data_valid, busy, timeout;
  logic [31:0] data_out;
  logic        halt1, data_valid1, busy1, timeout1;
  logic [31:0] data_out1;

  int          n_checks = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  int          v0;
  bit          model_busy = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] exp1_q[$];

  always #5 clock = ~clock;

  input_port_ctrl #(
    .DATA_W(16), .CHANNELS(2), .CH_W(1), .OUT_W(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
`ifdef IN_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clock(clock), .reset(reset), .in_req(in_req), .in_chan(in_chan), .in_signed(in_signed),
    .switches(switches), .confirm_btn(confirm_btn), .halt(halt), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .timeout(timeout)
  );

  input_port_ctrl #(
    .DATA_W(16), .CHANNELS(1), .CH_W(1), .OUT_W(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
`ifdef IN_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut1 (
    .clock(clock), .reset(reset), .in_req(in_req), .in_chan(in_chan), .in_signed(in_signed),
    .switches(switches[15:0]), .confirm_btn(confirm_btn), .halt(halt1), .data_out(data_out1),
    .data_valid(data_valid1), .busy(busy1), .timeout(timeout1)
  );

  // Count data_valid strobes of the main instance.
  always @(negedge clock) begin
    if (data_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

  // Issue a 1-cycle request; queue the expected result only if the model is idle.
  task automatic do_req(input logic chan, input logic sgn);
    logic [15:0] bank;
    in_req = 1'b1; in_chan = chan; in_signed = sgn;
    bank = chan ? switches[31:16] : switches[15:0];
    if (!model_busy) begin
      exp_q.push_back(ext16(bank, sgn));
      exp1_q.push_back(chan ? 32'h0000_0000 : ext16(switches[15:0], sgn));
      model_busy = 1'b1;
    end
    @(negedge clock);
    in_req = 1'b0;
    check_val("halt_after_req", {31'd0, halt}, 32'd1);
    check_val("busy_after_req", {31'd0, busy}, 32'd1);
  endtask

  // Wait for data_valid (bounded), compare against the scoreboard, check halt meanwhile.
  task automatic wait_valid(input int budget, input logic exp_tmo);
    bit got = 1'b0;
    bit got1 = 1'b0;
    logic [31:0] e = 32'h0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (data_valid1 === 1'b1) begin
        got1 = 1'b1;
        if (exp1_q.size() > 0) check_val("ch1_data_out", data_out1, exp1_q.pop_front());
        else check_val("ch1_unexpected_valid", 32'd1, 32'd0);
      end
      if (data_valid === 1'b1) begin
        got = 1'b1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else check_val("unexpected_valid", 32'd1, 32'd0);
        check_val("data_out", data_out, e);
        check_val("halt_at_valid", {31'd0, halt}, 32'd0);
        check_val("busy_at_valid", {31'd0, busy}, 32'd1);
        check_val("timeout_at_valid", {31'd0, timeout}, {31'd0, exp_tmo});
      end else begin
        check_val("halt_hold", {31'd0, halt}, 32'd1);
      end
    end
    check_val("valid_seen", {31'd0, got}, 32'd1);
    check_val("ch1_valid_seen", {31'd0, got1}, 32'd1);
    model_busy = 1'b0;
    @(negedge clock);
    check_val("valid_one_cycle", {31'd0, data_valid}, 32'd0);
    check_val("data_out_held", data_out, e);
  endtask

  task automatic press_btn();
    confirm_btn = 1'b1;
    wait_valid(40, 1'b0);
    confirm_btn = 1'b0;
    tick(12);
  endtask

  initial begin
    reset = 1'b1; in_req = 1'b0; in_chan = 1'b0; in_signed = 1'b0;
    confirm_btn = 1'b1; switches = 32'h0;

    // 1. Reset with button high
    tick(3);
    check_val("rst_halt", {31'd0, halt}, 32'd0);
    check_val("rst_data_out", data_out, 32'd0);
    check_val("rst_valid", {31'd0, data_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0; confirm_btn = 1'b0;
    tick(12);
    check_val("idle_busy", {31'd0, busy}, 32'd0);

    // 2. Unsigned capture from bank 1
    switches = {16'h8001, 16'h7FFF};
    v0 = valid_cnt;
    do_req(1'b1, 1'b0);
    tick(2);
    press_btn();
    check_val("unsigned_value", data_out, 32'h0000_8001);
    check_val("single_valid", valid_cnt - v0, 32'd1);

    // 3. Sign extension
    do_req(1'b1, 1'b1);
    press_btn();
    check_val("signed_neg", data_out, 32'hFFFF_8001);
    do_req(1'b0, 1'b1);
    press_btn();
    check_val("signed_pos", data_out, 32'h0000_7FFF);
    switches[15:0] = 16'hA5A5;
    do_req(1'b0, 1'b1);
    press_btn();
    do_req(1'b0, 1'b0);
    press_btn();

`ifndef IN_TIMEOUT_EN
    // 4. Held button, then glitches in WAIT
    confirm_btn = 1'b1;
    tick(12);
    switches[31:16] = 16'h1234;
    v0 = valid_cnt;
    do_req(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_val("halt_btn_held", {31'd0, halt}, 32'd1);
    end
    check_val("held_no_capture", valid_cnt - v0, 32'd0);
    confirm_btn = 1'b0;
    tick(12);
    for (int g = 0; g < 3; g++) begin
      confirm_btn = 1'b1; tick(3);
      confirm_btn = 1'b0; tick(8);
    end
    check_val("glitch_no_capture", valid_cnt - v0, 32'd0);
    check_val("glitch_busy", {31'd0, busy}, 32'd1);
    press_btn();
    check_val("after_glitch_value", data_out, 32'h0000_1234);
`endif

    // 5. Request while busy is ignored
    switches[31:16] = 16'h8001;
    v0 = valid_cnt;
    do_req(1'b1, 1'b1);
    tick(2);
    do_req(1'b0, 1'b0);
    press_btn();
    check_val("busy_req_ignored", data_out, 32'hFFFF_8001);
    check_val("busy_single_valid", valid_cnt - v0, 32'd1);
    check_val("queue_empty", exp_q.size(), 32'd0);

    // 6. Reset while waiting
    do_req(1'b1, 1'b0);
    tick(4);
    v0 = valid_cnt;
    reset = 1'b1;
    @(negedge clock);
    check_val("midrst_halt", {31'd0, halt}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_data_out", data_out, 32'd0);
    check_val("midrst_valid", {31'd0, data_valid}, 32'd0);
    reset = 1'b0;
    exp_q.delete(); exp1_q.delete(); model_busy = 1'b0;
    tick(6);
    check_val("midrst_no_valid", valid_cnt - v0, 32'd0);
    do_req(1'b0, 1'b1);
    press_btn();

`ifdef IN_TIMEOUT_EN
    // Timeout with no press
    do_req(1'b1, 1'b0);
    exp_q.delete(); exp1_q.delete();
    exp_q.push_back(32'h0); exp1_q.push_back(32'h0);
    wait_valid(40, 1'b1);
    check_val("timeout_data_zero", data_out, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
